// File: rtl/obi_rr_arbiter.sv
// N-to-1 OBI arbiter: round-robin A channel with a grant lock,
// in-order R-channel routing through an index FIFO.
module obi_rr_arbiter #(
    parameter int unsigned NumSbrPorts = 4,
    parameter int unsigned NumMaxTrans = 4,
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned IdWidth     = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NumSbrPorts-1:0]             sbr_req_i,
    output logic [NumSbrPorts-1:0]             sbr_gnt_o,
    input  logic [NumSbrPorts*AddrWidth-1:0]   sbr_addr_i,
    input  logic [NumSbrPorts-1:0]             sbr_we_i,
    input  logic [NumSbrPorts*DataWidth/8-1:0] sbr_be_i,
    input  logic [NumSbrPorts*DataWidth-1:0]   sbr_wdata_i,
    input  logic [NumSbrPorts*IdWidth-1:0]     sbr_aid_i,
    output logic [NumSbrPorts-1:0]             sbr_rvalid_o,
    output logic [DataWidth-1:0]               sbr_rdata_o,
    output logic                               sbr_err_o,
    output logic [IdWidth-1:0]                 sbr_rid_o,
    output logic                               mgr_req_o,
    input  logic                               mgr_gnt_i,
    output logic [AddrWidth-1:0]               mgr_addr_o,
    output logic                               mgr_we_o,
    output logic [DataWidth/8-1:0]             mgr_be_o,
    output logic [DataWidth-1:0]               mgr_wdata_o,
    output logic [IdWidth-1:0]                 mgr_aid_o,
    input  logic                               mgr_rvalid_i,
    input  logic [DataWidth-1:0]               mgr_rdata_i,
    input  logic                               mgr_err_i,
    input  logic [IdWidth-1:0]                 mgr_rid_i,
    output logic                               busy_o,
    output logic                               rsp_unexp_o
);

    localparam int unsigned IdxW = (NumSbrPorts > 1) ? $clog2(NumSbrPorts) : 1;
    localparam int unsigned PtrW = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
    localparam int unsigned CntW = $clog2(NumMaxTrans + 1);
    localparam int unsigned BeW  = DataWidth / 8;

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic [IdxW-1:0] fifo_q [NumMaxTrans];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            rsp_unexp_q;

    logic [IdxW-1:0] rr_win, winner;
    logic            rr_any, req_sel, full, hs, pop;
    int unsigned     cand;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(NumMaxTrans - 1)) ? '0 : p + 1'b1;
    endfunction

    // Lowest offset from rr_ptr wins; iterate downward so it is assigned last.
    always_comb begin
        rr_win = rr_ptr_q;
        rr_any = 1'b0;
        cand   = 0;
        for (int i = NumSbrPorts - 1; i >= 0; i--) begin
            cand = 32'(rr_ptr_q) + 32'(i);
            if (cand >= NumSbrPorts) cand = cand - NumSbrPorts;
            if (sbr_req_i[cand[IdxW-1:0]]) begin
                rr_win = cand[IdxW-1:0];
                rr_any = 1'b1;
            end
        end
    end

    always_comb begin
        winner    = (state_q == LOCKED) ? lock_idx_q : rr_win;
        req_sel   = (state_q == LOCKED) ? sbr_req_i[lock_idx_q] : rr_any;
        full      = (count_q == CntW'(NumMaxTrans));
        mgr_req_o = req_sel && !full;
        hs        = mgr_req_o && mgr_gnt_i;
        pop       = mgr_rvalid_i && (count_q != '0);
    end

    always_comb begin
        mgr_addr_o  = '0;
        mgr_we_o    = 1'b0;
        mgr_be_o    = '0;
        mgr_wdata_o = '0;
        mgr_aid_o   = '0;
        if (mgr_req_o) begin
            mgr_addr_o  = sbr_addr_i[winner*AddrWidth +: AddrWidth];
            mgr_we_o    = sbr_we_i[winner];
            mgr_be_o    = sbr_be_i[winner*BeW +: BeW];
            mgr_wdata_o = sbr_wdata_i[winner*DataWidth +: DataWidth];
            mgr_aid_o   = sbr_aid_i[winner*IdWidth +: IdWidth];
        end
    end

    always_comb begin
        sbr_gnt_o    = '0;
        sbr_rvalid_o = '0;
        if (hs) sbr_gnt_o[winner] = 1'b1;
        if (pop) sbr_rvalid_o[fifo_q[rd_ptr_q]] = 1'b1;
    end

    assign sbr_rdata_o = mgr_rdata_i;
    assign sbr_err_o   = mgr_err_i;
    assign sbr_rid_o   = mgr_rid_i;
    assign busy_o      = (count_q != '0);
    assign rsp_unexp_o = rsp_unexp_q;

    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (mgr_req_o && !mgr_gnt_i) begin
                    state_d    = LOCKED;
                    lock_idx_d = rr_win;
                end
            end
            LOCKED: begin
                if (hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (hs) begin
            rr_ptr_d = (winner == IdxW'(NumSbrPorts - 1)) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            lock_idx_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rsp_unexp_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
            if (hs) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (hs && !pop) count_q <= count_q + 1'b1;
            else if (!hs && pop) count_q <= count_q - 1'b1;
            if (mgr_rvalid_i && (count_q == '0)) rsp_unexp_q <= 1'b1;
        end
    end

    // Index storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (hs) fifo_q[wr_ptr_q] <= winner;
    end

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Directed bench for obi_rr_arbiter; expected response routing is
// queued at grant time and checked when the response is driven.
module tb_obi_rr_arbiter;

    localparam int N  = 4;
    localparam int M  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      sbr_req = '0;
    logic [N-1:0]      sbr_gnt;
    logic [N*AW-1:0]   sbr_addr;
    logic [N-1:0]      sbr_we;
    logic [N*DW/8-1:0] sbr_be;
    logic [N*DW-1:0]   sbr_wdata;
    logic [N*IW-1:0]   sbr_aid;
    logic [N-1:0]      sbr_rvalid;
    logic [DW-1:0]     sbr_rdata;
    logic              sbr_err;
    logic [IW-1:0]     sbr_rid;
    logic              mgr_req;
    logic              mgr_gnt = 1'b0;
    logic [AW-1:0]     mgr_addr;
    logic              mgr_we;
    logic [DW/8-1:0]   mgr_be;
    logic [DW-1:0]     mgr_wdata;
    logic [IW-1:0]     mgr_aid;
    logic              mgr_rvalid = 1'b0;
    logic [DW-1:0]     mgr_rdata = '0;
    logic              mgr_err = 1'b0;
    logic [IW-1:0]     mgr_rid = '0;
    logic              busy;
    logic              rsp_unexp;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    obi_rr_arbiter #(
        .NumSbrPorts(N), .NumMaxTrans(M), .AddrWidth(AW),
        .DataWidth(DW), .IdWidth(IW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .sbr_req_i(sbr_req), .sbr_gnt_o(sbr_gnt),
        .sbr_addr_i(sbr_addr), .sbr_we_i(sbr_we), .sbr_be_i(sbr_be),
        .sbr_wdata_i(sbr_wdata), .sbr_aid_i(sbr_aid),
        .sbr_rvalid_o(sbr_rvalid), .sbr_rdata_o(sbr_rdata),
        .sbr_err_o(sbr_err), .sbr_rid_o(sbr_rid),
        .mgr_req_o(mgr_req), .mgr_gnt_i(mgr_gnt),
        .mgr_addr_o(mgr_addr), .mgr_we_o(mgr_we), .mgr_be_o(mgr_be),
        .mgr_wdata_o(mgr_wdata), .mgr_aid_o(mgr_aid),
        .mgr_rvalid_i(mgr_rvalid), .mgr_rdata_i(mgr_rdata),
        .mgr_err_i(mgr_err), .mgr_rid_i(mgr_rid),
        .busy_o(busy), .rsp_unexp_o(rsp_unexp)
    );

    always #5 clk = ~clk;

    function automatic logic [AW-1:0] addr_of(input int p);
        return 32'h1000_0000 + 32'(p) * 32'h100;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive request mask with grant high and expect port p to win.
    task automatic grant(input logic [N-1:0] req, input int p);
        sbr_req = req;
        mgr_gnt = 1'b1;
        #1;
        check("grant", 64'(sbr_gnt), 64'(1 << p));
        check("gaddr", 64'(mgr_addr), 64'(addr_of(p)));
        exp_q.push_back(p);
        tick();
        mgr_gnt = 1'b0;
    endtask

    task automatic rsp(input logic [DW-1:0] data, input logic [IW-1:0] rid);
        int p;
        mgr_rvalid = 1'b1;
        mgr_rdata  = data;
        mgr_rid    = rid;
        #1;
        if (exp_q.size() == 0) begin
            check("sb_empty", 64'(exp_q.size()), 64'd1);
        end else begin
            p = exp_q.pop_front();
            check("rvalid", 64'(sbr_rvalid), 64'(1 << p));
            check("rdata", 64'(sbr_rdata), 64'(data));
            check("rid", 64'(sbr_rid), 64'(rid));
        end
        tick();
        mgr_rvalid = 1'b0;
    endtask

    initial begin
        for (int p = 0; p < N; p++) begin
            sbr_addr[p*AW +: AW]    = addr_of(p);
            sbr_we[p]               = p[0];
            sbr_be[p*DW/8 +: DW/8]  = 4'hF;
            sbr_wdata[p*DW +: DW]   = 32'hD000_0000 + 32'(p);
            sbr_aid[p*IW +: IW]     = p[IW-1:0];
        end
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_req", 64'(mgr_req), 64'd0);
        check("rst_gnt", 64'(sbr_gnt), 64'd0);
        check("rst_rvalid", 64'(sbr_rvalid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_unexp", 64'(rsp_unexp), 64'd0);

        // Alternating grants between 0 and 2, filling the outstanding cap
        grant(4'b0101, 0);
        grant(4'b0101, 2);
        grant(4'b0101, 0);
        grant(4'b0101, 2);
        sbr_req = 4'b0101;
        mgr_gnt = 1'b1;
        #1;
        check("full_req", 64'(mgr_req), 64'd0);
        check("full_gnt", 64'(sbr_gnt), 64'd0);
        check("full_busy", 64'(busy), 64'd1);
        // Pop while full: still no grant this cycle
        mgr_rvalid = 1'b1;
        mgr_rdata  = 32'h11;
        #1;
        check("full_pop_req", 64'(mgr_req), 64'd0);
        check("full_pop_rv", 64'(sbr_rvalid), 64'(1 << exp_q.pop_front()));
        tick();
        mgr_rvalid = 1'b0;
        mgr_gnt    = 1'b0;
        #1;
        check("refill_req", 64'(mgr_req), 64'd1);
        grant(4'b0101, 0);
        sbr_req = '0;
        rsp(32'h22, 2'd0);
        rsp(32'h33, 2'd1);
        rsp(32'h44, 2'd2);
        rsp(32'h55, 2'd3);
        check("drain_busy", 64'(busy), 64'd0);

        // Grants to 3,1,3 then in-order responses
        grant(4'b1000, 3);
        grant(4'b0010, 1);
        grant(4'b1000, 3);
        sbr_req = '0;
        rsp(32'hA, 2'd3);
        rsp(32'hB, 2'd1);
        rsp(32'hC, 2'd3);

        // Lock: port 1 waits, port 0 joins but cannot preempt
        sbr_req = 4'b0010;
        mgr_gnt = 1'b0;
        #1;
        check("lock_addr0", 64'(mgr_addr), 64'(addr_of(1)));
        check("lock_gnt0", 64'(sbr_gnt), 64'd0);
        tick();
        for (int c = 1; c < 3; c++) begin
            sbr_req = 4'b0011;
            #1;
            check("lock_addr", 64'(mgr_addr), 64'(addr_of(1)));
            check("lock_aid", 64'(mgr_aid), 64'd1);
            check("lock_gnt", 64'(sbr_gnt), 64'd0);
            tick();
        end
        grant(4'b0011, 1);
        sbr_req = '0;
        rsp(32'hBEEF, 2'd1);

        // Response with nothing outstanding
        mgr_rvalid = 1'b1;
        #1;
        check("unexp_rv", 64'(sbr_rvalid), 64'd0);
        tick();
        mgr_rvalid = 1'b0;
        #1;
        check("unexp_set", 64'(rsp_unexp), 64'd1);
        tick();
        check("unexp_hold", 64'(rsp_unexp), 64'd1);

        // Reset with two outstanding
        grant(4'b0001, 0);
        grant(4'b0001, 0);
        sbr_req = '0;
        #1;
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_req", 64'(mgr_req), 64'd0);
        check("mid_rst_unexp", 64'(rsp_unexp), 64'd0);
        grant(4'b1111, 0);
        sbr_req = '0;
        rsp(32'h77, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
